bp_queue: RTL and testbench

//   Decouples branch-predictor responses from decode. Captures each fetch prediction request
//   (fetch_bp_req/fetch_bp_addr), pairs it with brpred_bptag/brpred_bptaken returned one

---
 rtl/bp_pkg.sv | 15 +
 rtl/bp_queue_sync_fifo.sv | 61 ++++++
 rtl/bp_queue.sv | 84 ++++++++
 tb/tb_bp_queue.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared branch-predictor constants and the queued prediction record.
package bp_pkg;

  localparam int unsigned BPTAG_W = 16;
  localparam int unsigned PC_W    = 30;

  typedef struct packed {
    logic [PC_W-1:0]    addr;
    logic [BPTAG_W-1:0] bptag;
    logic               bptaken;
  } bp_entry_t;

  localparam int unsigned BP_ENTRY_W = $bits(bp_entry_t);

endpackage

// File: rtl/bp_queue_sync_fifo.sv
// Generic register-array FIFO with synchronous clear; read data is combinational from head.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             full;
  logic             wr_ok;
  logic             rd_ok;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign wr_ok   = wr_en & (~full | rd_en);
  assign rd_ok   = rd_en & ~empty;
  assign rd_data = mem[rd_ptr];

  // Entry storage: written at tail, deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers and occupancy; clear behaves like reset and overrides any transfer.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/bp_queue.sv
// Branch-prediction queue: pairs each fetch request with the predictor response one
// cycle later, buffers the results in order for decode, back-pressures fetch, and
// discards everything on a pipeline flush.
module bp_queue
  import bp_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               fetch_bp_req,
  input  logic [PC_W-1:0]    fetch_bp_addr,
  input  logic [BPTAG_W-1:0] brpred_bptag,
  input  logic               brpred_bptaken,
  input  logic               rob_flush,
  input  logic               decode_bpq_ready,
  output logic               bpq_stall,
  output logic               bpq_valid,
  output logic [PC_W-1:0]    bpq_addr,
  output logic [BPTAG_W-1:0] bpq_bptag,
  output logic               bpq_bptaken
);

  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  logic             acc;
  logic             enq;
  logic             deq;
  logic             pend_r;
  logic [PC_W-1:0]  addr_r;
  logic [CNT_W-1:0] count;
  logic             empty;
  logic [CNT_W:0]   occ;
  bp_entry_t        wr_entry;
  bp_entry_t        rd_entry;

  // Stall counts the in-flight request as occupied and ignores a same-cycle dequeue,
  // so it depends only on registered state.
  assign occ       = {1'b0, count} + {{CNT_W{1'b0}}, pend_r};
  assign bpq_stall = (occ >= (CNT_W+1)'(DEPTH));

  assign acc = fetch_bp_req & ~bpq_stall & ~rob_flush;
  assign enq = pend_r & ~rob_flush;
  assign deq = bpq_valid & decode_bpq_ready & ~rob_flush;

  assign wr_entry = '{addr: addr_r, bptag: brpred_bptag, bptaken: brpred_bptaken};

  // Hold the accepted request until its predictor response arrives next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_r <= 1'b0;
    end else begin
      pend_r <= acc;
    end
  end

  // Request address capture; only meaningful while pend_r is set.
  always_ff @(posedge clk) begin
    if (acc) begin
      addr_r <= fetch_bp_addr;
    end
  end

  sync_fifo #(
    .WIDTH (BP_ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .clr     (rob_flush),
    .wr_en   (enq),
    .wr_data (wr_entry),
    .rd_en   (deq),
    .rd_data (rd_entry),
    .count   (count),
    .empty   (empty)
  );

  assign bpq_valid   = ~empty;
  assign bpq_addr    = rd_entry.addr;
  assign bpq_bptag   = rd_entry.bptag;
  assign bpq_bptaken = rd_entry.bptaken;

endmodule

// File: tb/tb_bp_queue.sv
// Directed and randomized checks of bp_queue against hand values and a queue model.
module tb_bp_queue;
  import bp_pkg::*;

  localparam int unsigned DEPTH = 8;

  logic               clk;
  logic               rst;
  logic               fetch_bp_req;
  logic [PC_W-1:0]    fetch_bp_addr;
  logic [BPTAG_W-1:0] brpred_bptag;
  logic               brpred_bptaken;
  logic               rob_flush;
  logic               decode_bpq_ready;
  logic               bpq_stall;
  logic               bpq_valid;
  logic [PC_W-1:0]    bpq_addr;
  logic [BPTAG_W-1:0] bpq_bptag;
  logic               bpq_bptaken;

  bp_queue #(.DEPTH(DEPTH)) dut (
    .clk              (clk),
    .rst              (rst),
    .fetch_bp_req     (fetch_bp_req),
    .fetch_bp_addr    (fetch_bp_addr),
    .brpred_bptag     (brpred_bptag),
    .brpred_bptaken   (brpred_bptaken),
    .rob_flush        (rob_flush),
    .decode_bpq_ready (decode_bpq_ready),
    .bpq_stall        (bpq_stall),
    .bpq_valid        (bpq_valid),
    .bpq_addr         (bpq_addr),
    .bpq_bptag        (bpq_bptag),
    .bpq_bptaken      (bpq_bptaken)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  bp_entry_t       q[$];
  logic            m_pend;
  logic [PC_W-1:0] m_addr;
  int unsigned     m_tail;
  int unsigned     wraps;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    q.delete();
    m_pend = 1'b0;
    m_addr = '0;
    m_tail = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    fetch_bp_req = 1'b0; fetch_bp_addr = '0; brpred_bptag = '0; brpred_bptaken = 1'b0;
    rob_flush = 1'b0; decode_bpq_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
  endtask

  // Drive one cycle of inputs, advance the model, and wait past the edge.
  task automatic tick(input logic req, input logic [PC_W-1:0] addr, input logic [BPTAG_W-1:0] tag,
                      input logic tk, input logic fl, input logic rdy);
    logic stall, acc, enq, deq;
    bp_entry_t e;
    fetch_bp_req = req; fetch_bp_addr = addr; brpred_bptag = tag; brpred_bptaken = tk;
    rob_flush = fl; decode_bpq_ready = rdy;
    stall = (q.size() + int'(m_pend)) >= DEPTH;
    acc   = req && !stall && !fl;
    enq   = m_pend && !fl;
    deq   = (q.size() != 0) && rdy && !fl;
    if (fl) begin
      q.delete();
      m_pend = 1'b0;
      m_tail = 0;
    end else begin
      if (deq) void'(q.pop_front());
      if (enq) begin
        e.addr = m_addr; e.bptag = tag; e.bptaken = tk;
        q.push_back(e);
        m_tail = (m_tail + 1) % DEPTH;
        if (m_tail == 0) wraps++;
      end
      m_pend = acc;
      if (acc) m_addr = addr;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, "_valid"}, bpq_valid, q.size() != 0);
    check({tag, "_stall"}, bpq_stall, (q.size() + int'(m_pend)) >= DEPTH);
    if (q.size() != 0) begin
      check({tag, "_head"}, {bpq_addr, bpq_bptag, bpq_bptaken}, q[0]);
    end
    check({tag, "_inv_cnt"}, dut.count <= DEPTH, 1'b1);
    check({tag, "_inv_occ"}, (int'(dut.count) + int'(dut.pend_r)) <= DEPTH, 1'b1);
  endtask

  initial begin
    wraps = 0;
    do_reset();

    // 1: single request, two-cycle latency, pop
    check("rst_valid", bpq_valid, 1'b0);
    check("rst_stall", bpq_stall, 1'b0);
    tick(1'b1, 30'h1000, 16'h0, 1'b0, 1'b0, 1'b0);
    check("t1_nobypass", bpq_valid, 1'b0);
    tick(1'b0, 30'h0, 16'h8123, 1'b1, 1'b0, 1'b0);
    check("t1_valid", bpq_valid, 1'b1);
    check("t1_addr", bpq_addr, 30'h1000);
    check("t1_tag", bpq_bptag, 16'h8123);
    check("t1_taken", bpq_bptaken, 1'b1);
    tick(1'b0, 30'h0, 16'h0, 1'b0, 1'b0, 1'b1);
    check("t1_popped", bpq_valid, 1'b0);

    // 2: fill to DEPTH, stall, ignored stalled request, ordered drain
    for (int i = 0; i < 8; i++) begin
      check("t2_stall_lo", bpq_stall, 1'b0);
      tick(1'b1, 30'h2000 + 30'(i), 16'hA000 + 16'(i) - 16'd1, (i % 2) == 0, 1'b0, 1'b0);
    end
    check("t2_stall_hi7", bpq_stall, 1'b1);
    tick(1'b0, 30'h0, 16'hA007, 1'b1, 1'b0, 1'b0);
    check("t2_stall_full", bpq_stall, 1'b1);
    tick(1'b1, 30'h3FFF, 16'h0, 1'b0, 1'b0, 1'b0);
    check("t2_stall_ign", bpq_stall, 1'b1);
    check_model("t2_full");
    for (int i = 0; i < 8; i++) begin
      check("t2_drain_addr", bpq_addr, 30'h2000 + 30'(i));
      check("t2_drain_tag", bpq_bptag, 16'hA000 + 16'(i));
      check("t2_drain_tk", bpq_bptaken, (i % 2) == 1);
      tick(1'b0, 30'h0, 16'h0, 1'b0, 1'b0, 1'b1);
    end
    check("t2_empty", bpq_valid, 1'b0);

    // 3: start full, then request whenever not stalled while decode pops every cycle
    for (int i = 0; i < 9; i++) begin
      tick(i < 8, 30'h7000 + 30'(i), 16'hC000 + 16'(i), i[0], 1'b0, 1'b0);
    end
    check("t3_full", bpq_stall, 1'b1);
    for (int i = 0; i < 20; i++) begin
      tick((q.size() + int'(m_pend)) < DEPTH, 30'h7100 + 30'(i), 16'hC100 + 16'(i), i[1], 1'b0, 1'b1);
      check_model("t3");
    end

    // 4: flush as a response arrives with 3 entries queued
    do_reset();
    tick(1'b1, 30'h4000, 16'h0,    1'b0, 1'b0, 1'b0);
    tick(1'b1, 30'h4001, 16'h1110, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 30'h4002, 16'h1111, 1'b1, 1'b0, 1'b0);
    tick(1'b1, 30'h4003, 16'h1112, 1'b0, 1'b0, 1'b0);
    check("t4_pre_addr", bpq_addr, 30'h4000);
    tick(1'b0, 30'h0, 16'h1113, 1'b1, 1'b1, 1'b0);
    check("t4_flush_valid", bpq_valid, 1'b0);
    check("t4_flush_stall", bpq_stall, 1'b0);
    tick(1'b1, 30'h5000, 16'h0, 1'b0, 1'b0, 1'b0);
    check("t4_f1_valid", bpq_valid, 1'b0);
    tick(1'b0, 30'h0, 16'h5A5A, 1'b1, 1'b0, 1'b0);
    check("t4_new_valid", bpq_valid, 1'b1);
    check("t4_new_addr", bpq_addr, 30'h5000);
    check("t4_new_tag", bpq_bptag, 16'h5A5A);
    tick(1'b0, 30'h0, 16'h0, 1'b0, 1'b0, 1'b1);
    check("t4_only", bpq_valid, 1'b0);

    // 5: flush coincident with a request
    tick(1'b1, 30'h6000, 16'h0, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 30'h6001, 16'h2222, 1'b1, 1'b1, 1'b0);
    tick(1'b0, 30'h0, 16'hBEEF, 1'b1, 1'b0, 1'b0);
    check("t5_valid", bpq_valid, 1'b0);
    check("t5_stall", bpq_stall, 1'b0);
    tick(1'b0, 30'h0, 16'h0, 1'b0, 1'b0, 1'b0);
    check("t5_valid2", bpq_valid, 1'b0);
    check_model("t5");

    // 6: random traffic against the model
    wraps = 0;
    for (int i = 0; i < 10000; i++) begin
      tick($urandom_range(0, 99) < 60, 30'($urandom), 16'($urandom), 1'($urandom),
           $urandom_range(0, 63) == 0, $urandom_range(0, 99) < 55);
      check_model("rnd");
    end
    check("rnd_wraps_ge_100", wraps >= 100, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
